// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - startup reset sequencer: lock qualify, reset hold, optional BRAM zero-fill
// Optional BRAM clear sweep is compiled in with CLK_RST_SEQ_BRAM_CLEAR_EN.
module clk_rst_seq #(
  parameter int LOCK_WAIT = 1024,
  parameter int RST_HOLD  = 16,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 128
) (
  input  logic              clk0,
  input  logic              rst,
  input  logic              locked,
  output logic              sys_rst,
  output logic              ready,
  output logic              lock_lost,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din
);

  localparam int CNT_MAX = (LOCK_WAIT > RST_HOLD) ? LOCK_WAIT : RST_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {WAIT_LOCK, STABLE, HOLD, CLEAR, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             locked_s;
`ifdef CLK_RST_SEQ_BRAM_CLEAR_EN
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
`endif

  always_ff @(posedge clk0) begin
    if (rst) begin
      sync1     <= 1'b0;
      locked_s  <= 1'b0;
      state     <= WAIT_LOCK;
      cnt       <= '0;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
`ifdef CLK_RST_SEQ_BRAM_CLEAR_EN
      clr_we    <= 1'b0;
      clr_addr  <= '0;
`endif
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
      // A qualified lock loss outranks every other transition once past WAIT_LOCK.
      if (state != WAIT_LOCK && !locked_s) begin
        state   <= WAIT_LOCK;
        cnt     <= '0;
        sys_rst <= 1'b1;
        ready   <= 1'b0;
        if (state != STABLE) lock_lost <= 1'b1;
`ifdef CLK_RST_SEQ_BRAM_CLEAR_EN
        clr_we   <= 1'b0;
        clr_addr <= '0;
`endif
      end else begin
        case (state)
          WAIT_LOCK: begin
            cnt <= '0;
            if (locked_s) state <= STABLE;
          end
          STABLE: begin
            if (cnt == LOCK_LAST) begin
              state <= HOLD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              cnt <= '0;
`ifdef CLK_RST_SEQ_BRAM_CLEAR_EN
              state    <= CLEAR;
              clr_we   <= 1'b1;
              clr_addr <= '0;
`else
              state   <= RUN;
              sys_rst <= 1'b0;
              ready   <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef CLK_RST_SEQ_BRAM_CLEAR_EN
          CLEAR: begin
            if (clr_addr == {ADDR_W{1'b1}}) begin
              state    <= RUN;
              clr_we   <= 1'b0;
              clr_addr <= '0;
              sys_rst  <= 1'b0;
              ready    <= 1'b1;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

`ifdef CLK_RST_SEQ_BRAM_CLEAR_EN
  assign bram_we   = clr_we;
  assign bram_addr = clr_addr;
`else
  assign bram_we   = 1'b0;
  assign bram_addr = '0;
`endif
  assign bram_din = '0;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - directed table-driven bench for clk_rst_seq (follows CLK_RST_SEQ_BRAM_CLEAR_EN)
module tb_clk_rst_seq;

  localparam int LW = 8;
  localparam int RH = 4;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;
`ifdef CLK_RST_SEQ_BRAM_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif
  localparam int C_E   = 2 + LW + RH;
  localparam int RUN_E = C_E + CLR * DEPTH;

  logic          clk0 = 1'b0;
  logic          rst = 1'b1;
  logic          locked = 1'b0;
  logic          sys_rst, ready, lock_lost, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;

  clk_rst_seq #(.LOCK_WAIT(LW), .RST_HOLD(RH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk0(clk0), .rst(rst), .locked(locked), .sys_rst(sys_rst), .ready(ready),
    .lock_lost(lock_lost), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din)
  );

  always #5 clk0 = ~clk0;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  logic we_seen = 1'b0;

  always @(negedge clk0) if (!rst && bram_we) we_seen <= 1'b1;

  typedef struct {
    int   n;
    logic sys_rst;
    logic ready;
    logic we;
    int   addr;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s edge=%0d actual=%0d expected=%0d", name, edge_n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
    edge_n++;
  endtask

  task automatic go_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    locked = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic start_lock();
    locked = 1'b1;
    edge_n = -1;
  endtask

  initial begin
`ifdef CLK_RST_SEQ_BRAM_CLEAR_EN
    tbl.push_back('{0,  1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{2,  1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{9,  1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{13, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{14, 1'b1, 1'b0, 1'b1, 0});
    tbl.push_back('{15, 1'b1, 1'b0, 1'b1, 1});
    tbl.push_back('{16, 1'b1, 1'b0, 1'b1, 2});
    tbl.push_back('{17, 1'b1, 1'b0, 1'b1, 3});
    tbl.push_back('{18, 1'b1, 1'b0, 1'b1, 4});
    tbl.push_back('{19, 1'b1, 1'b0, 1'b1, 5});
    tbl.push_back('{20, 1'b1, 1'b0, 1'b1, 6});
    tbl.push_back('{21, 1'b1, 1'b0, 1'b1, 7});
    tbl.push_back('{22, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{24, 1'b0, 1'b1, 1'b0, 0});
`else
    tbl.push_back('{0,  1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{2,  1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{9,  1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{13, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{14, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{16, 1'b0, 1'b1, 1'b0, 0});
`endif

    // reset values with lock absent
    do_reset();
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_din", bram_din, 0);

    // steady lock from E0
    start_lock();
    foreach (tbl[i]) begin
      go_to(tbl[i].n);
      chk($sformatf("tbl%0d_sys_rst", tbl[i].n), sys_rst, tbl[i].sys_rst);
      chk($sformatf("tbl%0d_ready", tbl[i].n), ready, tbl[i].ready);
      chk($sformatf("tbl%0d_we", tbl[i].n), bram_we, tbl[i].we);
      chk($sformatf("tbl%0d_addr", tbl[i].n), bram_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_din", tbl[i].n), bram_din, 0);
      chk($sformatf("tbl%0d_lock_lost", tbl[i].n), lock_lost, 0);
    end
`ifndef CLK_RST_SEQ_BRAM_CLEAR_EN
    chk("we_never", we_seen, 0);
`endif

    // two-cycle glitch during STABLE at cnt=5, requalified at E10
    do_reset();
    start_lock();
    go_to(7);
    locked = 1'b0;
    go_to(9);
    locked = 1'b1;
    go_to(10 + RUN_E - 1);
    chk("glitch_pre_sys_rst", sys_rst, 1);
    chk("glitch_pre_ready", ready, 0);
    go_to(10 + RUN_E);
    chk("glitch_run_sys_rst", sys_rst, 0);
    chk("glitch_run_ready", ready, 1);
    chk("glitch_lock_lost", lock_lost, 0);

    // drop during CLEAR at addr 4 (HOLD when no clear sweep)
    do_reset();
    start_lock();
    go_to((CLR != 0) ? 18 : 10);
    chk("drop_pre_addr", bram_addr, (CLR != 0) ? 4 : 0);
    locked = 1'b0;
    tick();
    tick();
    chk("drop_f1_we", bram_we, CLR);
    chk("drop_f1_lock_lost", lock_lost, 0);
    tick();
    chk("drop_f2_we", bram_we, 0);
    chk("drop_f2_addr", bram_addr, 0);
    chk("drop_f2_sys_rst", sys_rst, 1);
    chk("drop_f2_lock_lost", lock_lost, 1);
    start_lock();
    go_to(C_E - 1);
    chk("relock_pre_we", bram_we, 0);
    go_to(C_E);
    chk("relock_clr_we", bram_we, CLR);
    chk("relock_clr_addr", bram_addr, 0);
    go_to(RUN_E);
    chk("relock_ready", ready, 1);
    chk("relock_lock_lost", lock_lost, 1);

    // rst clears the sticky flag
    do_reset();
    chk("rst2_lock_lost", lock_lost, 0);
    chk("rst2_sys_rst", sys_rst, 1);

    // drop in RUN
    start_lock();
    go_to(RUN_E + 2);
    chk("run_ready", ready, 1);
    locked = 1'b0;
    edge_n = -1;
    go_to(1);
    chk("run_f1_ready", ready, 1);
    chk("run_f1_lock_lost", lock_lost, 0);
    go_to(2);
    chk("run_f2_ready", ready, 0);
    chk("run_f2_sys_rst", sys_rst, 1);
    chk("run_f2_lock_lost", lock_lost, 1);
    start_lock();
    go_to(RUN_E);
    chk("run_relock_ready", ready, 1);
    chk("run_relock_lock_lost", lock_lost, 1);
    do_reset();
    chk("rst3_lock_lost", lock_lost, 0);
    chk("rst3_ready", ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
